ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Shares the single data port (port B) of the testbench dual-port RAM between several OBI-style requesters: core data interface, debug-module system bus access, and the DPI loader. It arbitrates one request per cycle, drives the RAM port-B controls combinationally from the winner, and routes the one-cycle-latency response back to the originating requester. It sits between the requesters and the RAM instance in the debug testbench top.

## Interface
- ADDR_WIDTH, 8: RAM byte-address width; must match the RAM instance.
- NUM_REQ, 2: number of requesters, 2..8.
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- req_i  in  NUM_REQ  per-requester request
- addr_i  in  NUM_REQ x ADDR_WIDTH  byte address
- we_i  in  NUM_REQ  1 = write
- be_i  in  NUM_REQ x 4  byte enables
- wdata_i  in  NUM_REQ x 32  write data
- gnt_o  out  NUM_REQ  grant, one-hot or zero
- rvalid_o  out  NUM_REQ  response valid, one-hot or zero
- rdata_o  out  32  response data, shared by all requesters, qualified by rvalid_o
- ram_en_o  out  1  to RAM en_b_i
- ram_addr_o  out  ADDR_WIDTH  to RAM addr_b_i
- ram_wdata_o  out  32  to RAM wdata_b_i
- ram_we_o  out  1  to RAM we_b_i
- ram_be_o  out  4  to RAM be_b_i
- ram_rdata_i  in  32  from RAM rdata_b_o

## Operation
- Each cycle, at most one requester with req_i high is granted; gnt_o[k] is combinational from req_i and the priority state.
- On grant k: ram_en_o=1 and ram_addr/wdata/we/be = requester k's fields, in the same cycle. With no grant: ram_en_o=0, other RAM outputs 0.
- Response tracking: registered resp_valid_q and resp_id_q (clog2(NUM_REQ) bits) capture grant and winner index. Next cycle rvalid_o[resp_id_q]=resp_valid_q.
- rdata_o = ram_rdata_i when the responded transaction was a read, else 0. Writes also return rvalid, with rdata_o=0.
- Requesters may issue back-to-back; throughput is one transaction per cycle with no bubbles.
- Requester obligation: hold req and fields stable until gnt. Withdrawal before grant is tolerated; no RAM access occurs.
- Priority pointer prio_q (clog2(NUM_REQ) bits) advances to (winner+1) mod NUM_REQ after each grant; it wraps from NUM_REQ-1 to 0 and is unchanged on idle cycles.

## Timing
- Grant latency: 0 cycles from req_i (combinational).
- Response latency: exactly 1 cycle after gnt.
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, ram_en_o=0, all ram_* outputs 0, prio_q=0, resp_valid_q=0, resp_id_q=0. While rst_i is high, gnt_o and ram_en_o are forced 0.
- Reset mid-operation: the pending response is discarded (no rvalid after reset deasserts). The RAM write is not undone.
- Simultaneous requests: the winner is the first requester at or after prio_q in increasing index, wrapping.
- Grant on the same cycle as a response to another requester: legal. The two are independent.

## Configuration
- RAM_ARB_ROUND_ROBIN_EN defined: round-robin priority as described above.
- Undefined: fixed priority, lowest index wins. prio_q is not implemented, and a constant 0 replaces it.

## Structure
- Package ram_arb_pkg: typedef ram_req_t {addr, we, be, wdata}, function for winner-index width, localparam RAM_DATA_WIDTH=32.
- Sub-module ram_arb_picker: owns prio_q and produces the one-hot grant plus the binary winner index. The top module holds the response registers and the muxing.

## Test plan
- Single read: RAM word 0x10 = 0xDEADBEEF, req0 read addr 0x10. Required response: gnt0 same cycle, ram_en_o=1, ram_addr_o=0x10; next cycle rvalid_o=01, rdata_o=0xDEADBEEF.
- Write then read: req1 writes 0xA5A5A5A5, be=0x3, to addr 0x20, which initially holds 0x00000000. Required response: rvalid1 with rdata_o=0. A subsequent read returns 0x0000A5A5.
- Contention (round-robin): req0 and req1 held high for 4 transactions from reset. Required response: grant order 0,1,0,1, with one rvalid per cycle matching the prior grant. With the macro undefined, the grant order is 0,0,0,0.
- Wrap: NUM_REQ=3, all requesting. Required response: grant order 0,1,2,0, confirming the pointer wraps.
- Reset mid-operation: assert rst_i in the cycle after a grant. Required response: no rvalid_o ever for that grant; all outputs 0; first post-reset grant goes to requester 0.
- Withdrawal: req1 pulses for one cycle while req0 is granted. Required response: req1 never granted, no RAM access for it, no rvalid1.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ============================================================================
// ram_arb_pkg : shared types and helpers for the RAM port-B arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package ram_arb_pkg;

    localparam int RAM_DATA_WIDTH     = 32;
    localparam int RAM_BE_WIDTH       = RAM_DATA_WIDTH / 8;
    localparam int RAM_ADDR_MAX_WIDTH = 32;

    // Address is carried at the widest supported size and narrowed at the RAM port.
    typedef struct packed {
        logic [RAM_ADDR_MAX_WIDTH-1:0] addr;
        logic                          we;
        logic [RAM_BE_WIDTH-1:0]       be;
        logic [RAM_DATA_WIDTH-1:0]     wdata;
    } ram_req_t;

    function automatic int ram_arb_idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_arb_picker.sv
// ============================================================================
// ram_arb_picker : one-hot grant and winner index for the RAM port arbiter.
// Round-robin when RAM_ARB_ROUND_ROBIN_EN is defined, else fixed lowest-index.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module ram_arb_picker
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = ram_arb_idx_width(NUM_REQ)
) (
`ifdef RAM_ARB_ROUND_ROBIN_EN
    input  logic               clk_i,
`endif
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_gnt;
    logic [IDX_W-1:0]   w_prio;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W:0]     w_cand;
    logic               w_found;

    // Nothing may be granted while reset is held.
    assign w_req = rst_i ? '0 : req_i;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_prio;
    logic [IDX_W-1:0] w_prio_nxt;

    assign w_prio_nxt = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : (w_idx + IDX_W'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_prio <= '0;
        end else if (w_found) begin
            r_prio <= w_prio_nxt;
        end
    end

    assign w_prio = r_prio;
`else
    assign w_prio = '0;
`endif

    // Scan from the priority pointer upward, wrapping at NUM_REQ.
    always_comb begin
        w_gnt   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = {1'b0, w_prio} + (IDX_W + 1)'(i);
            if (w_cand >= (IDX_W + 1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_W + 1)'(NUM_REQ);
            end
            if (!w_found && w_req[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_idx   = w_cand[IDX_W-1:0];
            end
        end
        if (w_found) begin
            w_gnt[w_idx] = 1'b1;
        end
    end

    assign gnt_o   = w_gnt;
    assign idx_o   = w_idx;
    assign valid_o = w_found;

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ============================================================================
// ram_port_arbiter : shares RAM port B between OBI-style requesters with a
// one-cycle response path. Option macro: RAM_ARB_ROUND_ROBIN_EN.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REQ    = 2
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [NUM_REQ-1:0]                        req_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]        addr_i,
    input  logic [NUM_REQ-1:0]                        we_i,
    input  logic [NUM_REQ-1:0][RAM_BE_WIDTH-1:0]      be_i,
    input  logic [NUM_REQ-1:0][RAM_DATA_WIDTH-1:0]    wdata_i,
    output logic [NUM_REQ-1:0]                        gnt_o,
    output logic [NUM_REQ-1:0]                        rvalid_o,
    output logic [RAM_DATA_WIDTH-1:0]                 rdata_o,
    output logic                                      ram_en_o,
    output logic [ADDR_WIDTH-1:0]                     ram_addr_o,
    output logic [RAM_DATA_WIDTH-1:0]                 ram_wdata_o,
    output logic                                      ram_we_o,
    output logic [RAM_BE_WIDTH-1:0]                   ram_be_o,
    input  logic [RAM_DATA_WIDTH-1:0]                 ram_rdata_i
);

    localparam int c_IDX_W = ram_arb_idx_width(NUM_REQ);

    logic [NUM_REQ-1:0] w_gnt;
    logic [c_IDX_W-1:0] w_win_idx;
    logic               w_win_valid;
    ram_req_t           w_sel;
    logic [NUM_REQ-1:0] w_rvalid;

    logic               r_resp_valid;
    logic [c_IDX_W-1:0] r_resp_id;
    logic               r_resp_we;

    ram_arb_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_picker (
`ifdef RAM_ARB_ROUND_ROBIN_EN
        .clk_i   (clk_i),
`endif
        .rst_i   (rst_i),
        .req_i   (req_i),
        .gnt_o   (w_gnt),
        .idx_o   (w_win_idx),
        .valid_o (w_win_valid)
    );

    // Idle port presents all-zero controls.
    always_comb begin
        w_sel = '0;
        if (w_win_valid) begin
            w_sel.addr  = RAM_ADDR_MAX_WIDTH'(addr_i[w_win_idx]);
            w_sel.we    = we_i[w_win_idx];
            w_sel.be    = be_i[w_win_idx];
            w_sel.wdata = wdata_i[w_win_idx];
        end
    end

    assign gnt_o       = w_gnt;
    assign ram_en_o    = w_win_valid;
    assign ram_addr_o  = w_sel.addr[ADDR_WIDTH-1:0];
    assign ram_we_o    = w_sel.we;
    assign ram_be_o    = w_sel.be;
    assign ram_wdata_o = w_sel.wdata;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_we    <= 1'b0;
        end else begin
            r_resp_valid <= w_win_valid;
            if (w_win_valid) begin
                r_resp_id <= w_win_idx;
                r_resp_we <= w_sel.we;
            end
        end
    end

    always_comb begin
        w_rvalid = '0;
        if (r_resp_valid) begin
            w_rvalid[r_resp_id] = 1'b1;
        end
    end

    assign rvalid_o = w_rvalid;
    // Write responses carry no data.
    assign rdata_o  = (r_resp_valid && !r_resp_we) ? ram_rdata_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
// tb_ram_port_arbiter : scoreboard bench for ram_port_arbiter with a RAM model.
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_ram_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 8;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]          req   = '0;
    logic [N-1:0][AW-1:0]  addr  = '0;
    logic [N-1:0]          we    = '0;
    logic [N-1:0][3:0]     be    = '0;
    logic [N-1:0][31:0]    wdata = '0;

    logic [N-1:0]  gnt;
    logic [N-1:0]  rvalid;
    logic [31:0]   rdata;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [31:0]   ram_rdata = '0;

    ram_port_arbiter #(
        .ADDR_WIDTH (AW),
        .NUM_REQ    (N)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .addr_i      (addr),
        .we_i        (we),
        .be_i        (be),
        .wdata_i     (wdata),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .ram_en_o    (ram_en),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_we_o    (ram_we),
        .ram_be_o    (ram_be),
        .ram_rdata_i (ram_rdata)
    );

    function automatic logic [31:0] be_mask(input logic [3:0] b);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (b[i]) m[i*8 +: 8] = 8'hFF;
        return m;
    endfunction

    // Behavioural RAM attached to port B (read-first, one-cycle latency).
    logic [31:0] mem [64] = '{4: 32'hDEADBEEF, default: 32'h0};
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= mem[ram_addr[7:2]];
            if (ram_we)
                mem[ram_addr[7:2]] <= (mem[ram_addr[7:2]] & ~be_mask(ram_be)) | (ram_wdata & be_mask(ram_be));
        end
    end

    // Reference model state
    logic [31:0] ref_mem [64] = '{4: 32'hDEADBEEF, default: 32'h0};
    int   m_prio   = 0;
    int   last_win = -1;
    int   gseq[$];
    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare whenever a response appears or one is overdue.
    always @(negedge clk) begin
        exp_t e;
        if (rvalid != '0) begin
            if (sb.size() == 0) begin
                chk("rvalid_unexpected", 64'(rvalid), 64'h0);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", 64'(rvalid), 64'(1) << e.id);
                chk("rsp_rdata", 64'(rdata), 64'(e.data));
                chk("rsp_latency", 64'(cyc), 64'(e.due));
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk("rsp_missing", 64'(rvalid), 64'(1) << e.id);
        end
    end

    // Evaluate the current cycle against the model (called at the falling edge).
    task automatic eval_cycle();
        int           w;
        logic [N-1:0] eg;
        exp_t         e;
        w = -1;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                int c;
                c = (m_prio + i) % N;
                if (w < 0 && req[c]) w = c;
            end
        end
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        chk("gnt", 64'(gnt), 64'(eg));
        chk("ram_en", 64'(ram_en), 64'(w >= 0));
        for (int k = 0; k < N; k++) if (gnt[k]) gseq.push_back(k);
        if (w >= 0) begin
            chk("ram_addr", 64'(ram_addr), 64'(addr[w]));
            chk("ram_we", 64'(ram_we), 64'(we[w]));
            chk("ram_be", 64'(ram_be), 64'(be[w]));
            chk("ram_wdata", 64'(ram_wdata), 64'(wdata[w]));
            e.id   = w;
            e.data = we[w] ? 32'h0 : ref_mem[addr[w][7:2]];
            e.due  = cyc + 1;
            sb.push_back(e);
            if (we[w])
                ref_mem[addr[w][7:2]] = (ref_mem[addr[w][7:2]] & ~be_mask(be[w])) | (wdata[w] & be_mask(be[w]));
`ifdef RAM_ARB_ROUND_ROBIN_EN
            m_prio = (w + 1) % N;
`endif
        end else begin
            chk("ram_idle_zero", {19'h0, ram_addr, ram_we, ram_be, ram_wdata}, 64'h0);
        end
        last_win = w;
    endtask

    task automatic step();
        @(negedge clk);
        eval_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        sb.delete();
        m_prio = 0;
        @(negedge clk);
        eval_cycle();
        chk("rst_rvalid", 64'(rvalid), 64'h0);
        chk("rst_rdata", 64'(rdata), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_txn(input int k, input logic [7:0] a, input logic w,
                           input logic [3:0] b, input logic [31:0] d);
        addr[k]  = a;
        we[k]    = w;
        be[k]    = b;
        wdata[k] = d;
        req[k]   = 1'b1;
    endtask

    task automatic rand_txn(input int k);
        set_txn(k, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), $urandom);
    endtask

    task automatic check_order(input string name, input int e0, input int e1,
                               input int e2, input int e3);
        int ex[4];
        ex = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++)
            chk(name, 64'((gseq.size() > i) ? gseq[i] : -1), 64'(ex[i]));
    endtask

    initial begin
        int ones;
        // Reset state, with every requester asserting during reset
        @(posedge clk);
        #1;
        req = '1;
        @(negedge clk);
        eval_cycle();
        chk("rst_rvalid", 64'(rvalid), 64'h0);
        chk("rst_rdata", 64'(rdata), 64'h0);
        @(posedge clk);
        #1;
        req = '0;
        rst = 1'b0;

        // Single read of the preloaded word
        set_txn(0, 8'h10, 1'b0, 4'hF, 32'h0);
        step();
        req[0] = 1'b0;
        step();

        // Partial write then read back
        set_txn(1, 8'h20, 1'b1, 4'h3, 32'hA5A5A5A5);
        step();
        set_txn(1, 8'h20, 1'b0, 4'hF, 32'h0);
        step();
        req[1] = 1'b0;
        step();

        // Two-way contention from reset
        do_reset();
        gseq.delete();
        rand_txn(0);
        rand_txn(1);
        repeat (4) begin
            step();
            if (last_win >= 0) rand_txn(last_win);
        end
        req = '0;
        step();
`ifdef RAM_ARB_ROUND_ROBIN_EN
        check_order("contention_order", 0, 1, 0, 1);
`else
        check_order("contention_order", 0, 0, 0, 0);
`endif

        // Three-way contention, pointer wrap
        do_reset();
        gseq.delete();
        for (int k = 0; k < N; k++) rand_txn(k);
        repeat (4) begin
            step();
            if (last_win >= 0) rand_txn(last_win);
        end
        req = '0;
        step();
`ifdef RAM_ARB_ROUND_ROBIN_EN
        check_order("wrap_order", 0, 1, 2, 0);
`else
        check_order("wrap_order", 0, 0, 0, 0);
`endif

        // Reset in the cycle after a grant
        do_reset();
        set_txn(0, 8'h10, 1'b0, 4'hF, 32'h0);
        step();
        do_reset();
        gseq.delete();
        rand_txn(0);
        rand_txn(1);
        step();
        chk("post_reset_first", 64'((gseq.size() > 0) ? gseq[0] : -1), 64'(0));
        req = '0;
        repeat (2) step();

        // Withdrawal of requester 1 while requester 0 is granted
        do_reset();
        gseq.delete();
        rand_txn(0);
        rand_txn(1);
        step();
        req = '0;
        repeat (3) step();
        ones = 0;
        foreach (gseq[i]) if (gseq[i] == 1) ones++;
        chk("withdraw_no_gnt1", 64'(ones), 64'h0);

        // Randomised traffic with occasional withdrawal and reset
        repeat (500) begin
            for (int k = 0; k < N; k++) begin
                if (!req[k] && $urandom_range(0, 2) == 0) rand_txn(k);
                else if (req[k] && $urandom_range(0, 15) == 0) req[k] = 1'b0;
            end
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step();
                if (last_win >= 0) req[last_win] = 1'b0;
            end
        end

        req = '0;
        repeat (3) step();
        chk("scoreboard_drained", 64'(sb.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
